// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types.
//   regbits_t      5-bit architectural register index
//   pctrl_state_t  pipeline sequencer state (RUN, DWAIT, HALTED)
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;

endpackage

// File: rtl/pipeline_hazard.sv
// pipeline_hazard: combinational load-use hazard detector.
// Ports:
//   ex_dREN  in   instruction in EX is a load
//   ex_wsel  in   its destination register
//   id_rs    in   first source register of the instruction in ID
//   id_rt    in   second source register of the instruction in ID
//   loaduse  out  ID needs a value the EX load has not produced yet
module pipeline_hazard
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_wsel,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     loaduse
);

  // Register 0 is hardwired to zero, so a load targeting it never hazards.
  assign loaduse = ex_dREN & (ex_wsel != '0) &
                   ((ex_wsel == id_rs) | (ex_wsel == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
// Arbitrates the single memory port (data access wins over fetch), latches
// the halt condition and counts stall cycles.
// Ports:
//   CLK, nRST                 clock, synchronous active-low reset
//   ihit, dhit                icache / dcache completion
//   mem_dREN, mem_dWEN        pending data access in MEM
//   mem_halt                  HALT reached MEM
//   ex_dREN, ex_wsel          load in EX and its destination
//   id_rs, id_rt              sources of the instruction in ID
//   branch_taken              EX-stage branch/jump taken
//   pc_en, imemREN            PC load enable, fetch request
//   *_en, *_flush             per-latch enables and bubble inserts
//   halted                    registered halt flag, sticky until reset
//   stall_cnt                 registered saturating stall-cycle count
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             ex_dREN,
  input  regbits_t         ex_wsel,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             imemREN,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exm_en,
  output logic             mwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exm_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  pctrl_state_t state_reg;
  logic         loaduse;
  logic         dacc;
  logic         adv;
  logic         halt_cycle;

  pipeline_hazard u_hazard (
    .ex_dREN (ex_dREN),
    .ex_wsel (ex_wsel),
    .id_rs   (id_rs),
    .id_rt   (id_rt),
    .loaduse (loaduse)
  );

  assign dacc = mem_dREN | mem_dWEN;

  always_comb begin
    adv        = 1'b0;
    halt_cycle = 1'b0;
    pc_en      = 1'b0;
    imemREN    = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exm_en     = 1'b0;
    mwb_en     = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exm_flush  = 1'b0;
    if (nRST) begin
      case (state_reg)
        RUN: begin
          if (mem_halt) halt_cycle = 1'b1;
          else          adv = dacc ? dhit : ihit;
        end
        // ihit is ignored while waiting; a dropped access gives no advance.
        DWAIT:   adv = dacc & dhit;
        default: adv = 1'b0;
      endcase

      if (halt_cycle) begin
        // Retire the HALT into WB and bubble EX/MEM; everything upstream freezes.
        mwb_en    = 1'b1;
        exm_en    = 1'b1;
        exm_flush = 1'b1;
      end else begin
        imemREN    = (state_reg == RUN) & ~dacc;
        idex_en    = adv;
        exm_en     = adv;
        mwb_en     = adv;
        idex_flush = adv & (branch_taken | loaduse);
        ifid_en    = adv & (branch_taken | ~loaduse);
        // Nothing was fetched while the port served data, so IF/ID takes a bubble.
        ifid_flush = adv & (branch_taken | (dacc & ~loaduse));
        pc_en      = adv & (branch_taken | (~dacc & ~loaduse));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg <= RUN;
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      // The halt cycle advances WB, so it is not counted as a stall.
      if ((state_reg != HALTED) && !adv && !halt_cycle && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;

      case (state_reg)
        RUN: begin
          if (mem_halt) begin
            state_reg <= HALTED;
            halted    <= 1'b1;
          end else if (dacc && !dhit) begin
            state_reg <= DWAIT;
          end
        end
        DWAIT: begin
          if (dhit || !dacc) state_reg <= RUN;
        end
        default: state_reg <= HALTED;
      endcase
    end
  end

endmodule
